// File: rtl/hex_step_pkg.sv
// Shared types and default constants for the hex step counter.
package hex_step_pkg;

  // Key-repeat FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Direction latched on the press that started the current hold.
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Board defaults for a 10 MHz clock.
  localparam int DEF_WIDTH        = 4;
  localparam int DEF_DEBOUNCE     = 100_000;
  localparam int DEF_REPEAT_DELAY = 5_000_000;
  localparam int DEF_REPEAT_RATE  = 1_000_000;

  // Larger of two integers, used to size the shared repeat timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_step_counter_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability-count debouncer and a
// registered one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
  import hex_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Bring the raw button into the clock domain; idle level is released (1).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // any return to the accepted level restarts the count.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = deb_q;
  assign press_o = press_q;

endmodule

// File: rtl/hex_step_counter.sv
// Debounced, auto-repeating up/down hex counter with switch parallel load,
// feeding the 7-segment decoder.
module hex_step_counter
  import hex_step_pkg::*;
#(
  parameter int WIDTH               = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE
) (
  input  logic             CLOCK_10,
  input  logic             RESET_N,
  input  logic             KEY_UP_N,
  input  logic             KEY_DN_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  output logic [WIDTH-1:0] VALUE,
  output logic             STEP
);

  localparam int TIMER_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int TW        = $clog2(TIMER_MAX + 1);

  logic up_level, up_press;
  logic dn_level, dn_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk_i   (CLOCK_10),
    .rst_ni  (RESET_N),
    .key_ni  (KEY_UP_N),
    .level_o (up_level),
    .press_o (up_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
    .clk_i   (CLOCK_10),
    .rst_ni  (RESET_N),
    .key_ni  (KEY_DN_N),
    .level_o (dn_level),
    .press_o (dn_press)
  );

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              step_q, step_d;
  logic              do_step;
  logic              active_released;

  // The key that started the hold is the only one watched for release.
  assign active_released = (dir_q == DIR_UP) ? up_level : dn_level;

  // Next-state logic: press / hold / repeat stepping, with LOAD overriding all.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    value_d = value_q;
    step_d  = 1'b0;
    do_step = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Simultaneous presses cancel each other.
        if (up_press ^ dn_press) begin
          do_step = 1'b1;
          dir_d   = up_press ? DIR_UP : DIR_DN;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (active_released) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(REPEAT_DELAY_CYCLES - 1)) begin
          do_step = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (active_released) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(REPEAT_RATE_CYCLES - 1)) begin
          do_step = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Wrap-around arithmetic falls out of the fixed register width.
    if (do_step) begin
      value_d = (dir_d == DIR_UP) ? (value_q + WIDTH'(1)) : (value_q - WIDTH'(1));
      step_d  = 1'b1;
    end

    // Switch load wins; any press seen this cycle is dropped.
    if (LOAD) begin
      value_d = LOAD_VALUE;
      state_d = IDLE;
      dir_d   = dir_q;
      timer_d = '0;
      step_d  = 1'b0;
    end
  end

  // FSM, timer and output registers.
  always_ff @(posedge CLOCK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      timer_q <= '0;
      value_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

  assign VALUE = value_q;
  assign STEP  = step_q;

endmodule
